// File: rtl/seq_mult_pkg.sv
// Shared types and latency helpers for seq_shift_add_mult.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the highest set bit; 0 for an all-zero value.
    function automatic int msb_index(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // Number of CALC cycles spent on multiplier b, with or without zero-pair skipping.
    function automatic logic [7:0] calc_cycles(input logic [31:0] b, input logic skip);
        logic [31:0] m;
        logic [7:0]  n;
        m = b;
        n = 8'd0;
        for (int i = 0; i < 32; i++) begin
            if (m != 32'd0) begin
                if (skip && (m[1:0] == 2'b00)) m = m >> 2;
                else                           m = m >> 1;
                n = n + 8'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_shift_add_mult_acc_adder.sv
// Ripple-carry accumulator adder; the addend is forced to zero when en is low
// so its operand lines stay quiet on cycles that add nothing.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module acc_adder #(
    parameter int W = 14
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] addend,
    input  logic         en,
    output logic [W-1:0] sum
);
    logic [W-1:0] addend_g;
    logic [W-1:0] carry;

    assign addend_g = en ? addend : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W - 1; i++) begin : g_fa
        full_adder u_fa (
            .x    (acc[i]),
            .y    (addend_g[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    // Product never exceeds W bits, so the top carry-out is not built.
    assign sum[W-1] = acc[W-1] ^ addend_g[W-1] ^ carry[W-1];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// Define SEQ_MULT_ZERO_SKIP_EN to consume two zero multiplier bits per cycle.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one (or two, when skipping) multiplier bits consumed per cycle
// DONE  | product presented on result with out_valid until out_ready
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int WA = 7,
    parameter int WB = 7,
    parameter int WR = WA + WB
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WR-1:0] result,
    output logic          busy
);

`ifdef SEQ_MULT_ZERO_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    state_t        state, state_nxt;
    logic [WR-1:0] mcand;
    logic [WB-1:0] mplier;
    logic [WR-1:0] acc;
    logic [WR-1:0] acc_sum;
    logic [WR-1:0] result_q;
    logic          accept;
    logic          last;
    logic          skip2;
    logic [7:0]    calc_cnt;
    logic [7:0]    calc_exp;

    assign accept = in_valid && (state == IDLE);
    assign last   = (mplier[WB-1:1] == '0);
    assign skip2  = SKIP_EN && (mplier[1:0] == 2'b00);

    acc_adder #(.W(WR)) u_acc_adder (
        .acc    (acc),
        .addend (mcand),
        .en     (mplier[0]),
        .sum    (acc_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (b == '0) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WB{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        if (b == '0) result_q <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_sum;
                    if (skip2) begin
                        mcand  <= mcand << 2;
                        mplier <= mplier >> 2;
                    end else begin
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (last) result_q <= acc_sum;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

    // CALC-length bookkeeping, only observed by the latency assertion below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_cnt <= 8'd0;
            calc_exp <= 8'd0;
        end else if (accept) begin
            calc_cnt <= 8'd0;
            calc_exp <= calc_cycles(32'(b), SKIP_EN);
        end else if (state == CALC) begin
            calc_cnt <= calc_cnt + 8'd1;
        end
    end

    a_calc_len: assert property (@(posedge clk) disable iff (!rst_n)
        (state == CALC && last) |-> (calc_cnt + 8'd1 == calc_exp));

endmodule
